wb_host: RTL and testbench
==========================

// Module: wb_host
// PURPOSE
//  Wishbone classic-mode initiator (bus master). It turns a valid/ready command stream {we, adr, dat}
//  into single Wishbone cycles and returns {rdata, err} on a valid/ready response channel.
//  Used by on-chip loaders and the bench to program cores, set pads, debug and seed entropy through the wishbone slave mux.
//  Adds a bounded ack timeout so a missing responder cannot hang the host.
// PARAMETERS
//  WB_WIDTH   32  address/data width of the bus and of the command/response payloads
//  TIMEOUT    16  max cycles with cyc/stb held before the cycle is aborted (>=2)
//  CNT_WIDTH  8   width of the saturating timeout event counter
// PORTS
//  clk            in   1          single clock
//  rst_n          in   1          asynchronous, active-low reset
//  cmd_valid      in   1          command offered
//  cmd_ready      out  1          command accepted when cmd_valid && cmd_ready
//  cmd_we         in   1          1=write, 0=read
//  cmd_adr        in   WB_WIDTH   bus address; [WB_WIDTH-1:WB_WIDTH-2] selects the interface
//  cmd_dat        in   WB_WIDTH   write data, ignored for reads
//  rsp_valid      out  1          response available
//  rsp_ready      in   1          response consumed when rsp_valid && rsp_ready
//  rsp_rdata      out  WB_WIDTH   read data; 0 for writes and for timeouts
//  rsp_err        out  1          1 = cycle timed out without ack
//  wbm_cyc_o      out  1          wb cycle
//  wbm_stb_o      out  1          wb strobe; always equal to wbm_cyc_o
//  wbm_we_o       out  1          wb write enable
//  wbm_adr_o      out  WB_WIDTH   wb address
//  wbm_dat_o      out  WB_WIDTH   wb write data
//  wbm_ack_i      in   1          wb acknowledge; may be combinational from stb
//  wbm_dat_i      in   WB_WIDTH   wb read data, sampled only with ack on a read
//  busy           out  1          high in BUS or RESP
//  timeout_cnt    out  CNT_WIDTH  saturating count of timed-out cycles
// BEHAVIOUR
//  Reset: state=IDLE. All of the following are 0: cmd_ready, rsp_valid, rsp_rdata, rsp_err, wbm_*_o, busy, timeout_cnt.
//   Reset acts immediately (async); cyc/stb drop in the same instant even mid-cycle.
//   A pending response is discarded. After reset deasserts, cmd_ready=1 from the first clock edge.
//  FSM IDLE -> BUS -> RESP -> IDLE. All outputs are registered. No combinational path cmd->wbm or wbm_ack_i->rsp.
//  IDLE
//   - cmd_ready=1.
//   - On accept: latch we/adr/dat into the wbm_*_o registers, zero the timer, go to BUS.
//   - wbm_dat_o is driven 0 for reads.
//  BUS
//   - cyc=stb=1; we/adr/dat stable for the whole cycle; cmd_ready=0.
//   - Timer increments every BUS cycle.
//   - ack=1: rsp_rdata=we?0:wbm_dat_i, rsp_err=0, drop cyc/stb, go to RESP.
//   - No ack with timer==TIMEOUT-1: rsp_rdata=0, rsp_err=1, drop cyc/stb, timeout_cnt+=1 (holds at all-ones), go to RESP.
//   - Ack in that same final cycle wins; it is a normal completion with no error.
//  RESP
//   - rsp_valid=1; rsp_rdata/rsp_err held stable until accepted.
//   - On rsp_ready: rsp_valid=0, rsp_rdata and rsp_err stay until the next completion, go to IDLE.
//   - cmd_valid is ignored throughout RESP.
//  Latency: accept at edge N; stb high N+1; with same-cycle ack rsp_valid high N+2; cmd_ready again N+3.
//   One transaction per 3 cycles maximum.
//  Stalled command: cmd_* may change freely while cmd_ready=0; only the accepting edge is sampled.
//  Stray ack: wbm_ack_i outside BUS is ignored.
// STRUCTURE
//  Shared include wb_defs.vh:
//   - WB_IF_PROG=2'b00, WB_IF_PADS=2'b01, WB_IF_DEBUG=2'b10, WB_IF_ENTROPY=2'b11
//   - state encodings ST_IDLE/ST_BUS/ST_RESP (2 bits)
//  Sub-module wb_host_timer: timer with clear/enable/expire at TIMEOUT-1, plus the saturating timeout_cnt.
//  FSM and datapath registers stay in wb_host.
// TESTING
//  1. Write, adr=0x0000_0105, dat=0xDEADBEEF, ack tied to stb
//     -> stb high exactly 1 cycle with those values, we=1; rsp err=0, rdata=0 two cycles after accept.
//  2. Read, adr=0x8000_0023, responder returns 0x1234 with ack
//     -> rsp_rdata=0x0000_1234, err=0; wbm_dat_o=0 during the cycle.
//  3. Read with ack delayed 5 cycles
//     -> cyc/stb/adr stable 6 cycles, no error; with TIMEOUT=16, ack at cycle 16 -> err=0.
//  4. Ack never asserted, TIMEOUT=16
//     -> stb high exactly 16 cycles then low, rsp_err=1, rdata=0, timeout_cnt=1.
//     Repeat 300x with CNT_WIDTH=8 -> timeout_cnt saturates at 255.
//  5. rsp_ready held low 7 cycles with cmd_valid held high
//     -> rsp stable, cmd_ready=0, no second stb; accepts the next command 1 cycle after rsp_ready.
//  6. rst_n pulsed low mid-BUS (cycle 3 of delayed ack)
//     -> cyc/stb low asynchronously, rsp_valid=0, timeout_cnt=0; next write completes normally.

Source files
------------

// File: rtl/wb_host_pkg.sv
// wb_host_pkg: interface selects (top two address bits) and host FSM state encodings
package wb_host_pkg;
  localparam logic [1:0] WB_IF_PROG    = 2'b00;
  localparam logic [1:0] WB_IF_PADS    = 2'b01;
  localparam logic [1:0] WB_IF_DEBUG   = 2'b10;
  localparam logic [1:0] WB_IF_ENTROPY = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } st_t;
endpackage

// File: rtl/wb_host_if.sv
// wb_host_if: cmd/rsp valid-ready channels plus wishbone initiator signals; master = host side, slave = user/responder side
interface wb_host_if #(
  parameter int WB_WIDTH = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [WB_WIDTH-1:0] cmd_adr;
  logic [WB_WIDTH-1:0] cmd_dat;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WB_WIDTH-1:0] rsp_rdata;
  logic                rsp_err;
  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic [WB_WIDTH-1:0] wbm_adr_o;
  logic [WB_WIDTH-1:0] wbm_dat_o;
  logic                wbm_ack_i;
  logic [WB_WIDTH-1:0] wbm_dat_i;
  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o
  );
  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_host_timer.sv
// wb_host_timer: per-cycle ack timer (clr/en, expire at TIMEOUT-1) and saturating count of unacked expiries
module wb_host_timer #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 ack,
  output logic                 expire,
  output logic [CNT_WIDTH-1:0] timeout_cnt
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] t;
  assign expire = en && t == LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t           <= '0;
      timeout_cnt <= '0;
    end else begin
      t <= clr ? '0 : en ? t + 1'b1 : t;
      if (expire && !ack && timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/wb_host.sv
// wb_host: wishbone classic initiator turning cmd{we,adr,dat} into single cycles, returning rsp{rdata,err} with ack timeout
module wb_host
  import wb_host_pkg::*;
#(
  parameter int WB_WIDTH  = 32,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_host_if.master            bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] timeout_cnt
);
  localparam logic [WB_WIDTH-1:0] ZERO = '0;
  st_t  state, state_n;
  logic accept, in_bus, expire, done;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign in_bus        = state == ST_BUS;
  assign done          = in_bus && (bus.wbm_ack_i || expire);
  assign bus.wbm_stb_o = bus.wbm_cyc_o;
  wb_host_timer #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk,
    .rst_n,
    .clr(accept),
    .en(in_bus),
    .ack(bus.wbm_ack_i),
    .expire,
    .timeout_cnt
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end
  always_comb begin
    state_n = state == ST_IDLE ? (accept ? ST_BUS : ST_IDLE)
            : in_bus           ? (done ? ST_RESP : ST_BUS)
            :                    (bus.rsp_ready ? ST_IDLE : ST_RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= ZERO;
      bus.rsp_err   <= 1'b0;
      bus.wbm_cyc_o <= 1'b0;
      bus.wbm_we_o  <= 1'b0;
      bus.wbm_adr_o <= ZERO;
      bus.wbm_dat_o <= ZERO;
    end else begin
      busy          <= state_n != ST_IDLE;
      bus.cmd_ready <= state_n == ST_IDLE;
      if (accept) begin
        bus.wbm_cyc_o <= 1'b1;
        bus.wbm_we_o  <= bus.cmd_we;
        bus.wbm_adr_o <= bus.cmd_adr;
        bus.wbm_dat_o <= bus.cmd_we ? bus.cmd_dat : ZERO;
      end
      if (done) begin
        bus.wbm_cyc_o <= 1'b0;
        bus.rsp_valid <= 1'b1;
        bus.rsp_rdata <= bus.wbm_ack_i && !bus.wbm_we_o ? bus.wbm_dat_i : ZERO;
        bus.rsp_err   <= !bus.wbm_ack_i;
      end
      if (state == ST_RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_host.sv
// tb_wb_host: vector table, hand sequences and randomized transactions against a transaction-level model
module tb_wb_host;
  import wb_host_pkg::*;
  localparam int TIMEOUT = 16;
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          dly;
    logic [31:0] rd;
    int          wt;
    logic [31:0] x_rdata;
    logic        x_err;
    int          x_len;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [7:0]  timeout_cnt;
  int          ack_delay = -1;
  int          stb_cnt = 0;
  logic [31:0] rd_data = '0;
  logic        stray = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          m_tcnt = 0;
  vec_t        tbl[7];
  wb_host_if #(.WB_WIDTH(32)) bus ();
  wb_host #(.WB_WIDTH(32), .TIMEOUT(TIMEOUT), .CNT_WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy),
    .timeout_cnt(timeout_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) stb_cnt <= bus.wbm_stb_o ? stb_cnt + 1 : 0;
  assign bus.wbm_ack_i = stray || (bus.wbm_stb_o && ack_delay >= 0 && stb_cnt == ack_delay);
  assign bus.wbm_dat_i = bus.wbm_ack_i ? rd_data : 32'hBAD0_0BAD;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [31:0] rd, input int dly,
                                output logic [31:0] r, output logic e, output int len);
    e   = !(dly >= 0 && dly < TIMEOUT);
    r   = (e || we) ? 32'h0 : rd;
    len = e ? TIMEOUT : dly + 1;
  endfunction

  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat, input int dly,
                     input logic [31:0] rd, input int wt, output int len, output int lat, output logic ok,
                     output logic [31:0] rdata, output logic err, output logic rdy_after);
    int guard = 0;
    ack_delay = dly;
    rd_data   = rd;
    ok        = 1'b1;
    len       = 0;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = ~we;
    bus.cmd_adr   = $urandom;
    bus.cmd_dat   = $urandom;
    while (bus.wbm_stb_o && len < 40) begin
      len++;
      if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_we_o !== we || bus.wbm_adr_o !== adr ||
          bus.wbm_dat_o !== (we ? dat : 32'h0) || bus.rsp_valid || bus.cmd_ready) ok = 1'b0;
      @(negedge clk);
    end
    lat   = bus.rsp_valid ? len + 1 : -1;
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.cmd_valid = 1'b1;
    stray = 1'b1;
    repeat (wt) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_rdata !== rdata || bus.rsp_err !== err || bus.cmd_ready || bus.wbm_stb_o)
        ok = 1'b0;
    end
    stray = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    rdy_after = bus.cmd_ready && !bus.rsp_valid && bus.rsp_rdata === rdata && bus.rsp_err === err;
  endtask

  task automatic run_check(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input int dly, input logic [31:0] rd, input int wt,
                           input logic [31:0] x_rdata, input logic x_err, input int x_len);
    int len, lat;
    logic ok, err, ra;
    logic [31:0] rdata;
    txn(we, adr, dat, dly, rd, wt, len, lat, ok, rdata, err, ra);
    chk({tag, "_rdata"}, 64'(rdata), 64'(x_rdata));
    chk({tag, "_err"}, 64'(err), 64'(x_err));
    chk({tag, "_stb_len"}, 64'(len), 64'(x_len));
    chk({tag, "_latency"}, 64'(lat), 64'(x_len + 1));
    chk({tag, "_stable"}, 64'(ok), 64'd1);
    chk({tag, "_ready_after"}, 64'(ra), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          len, dly;
    logic        we;
    logic [31:0] adr, dat, rd;
    tbl[0] = '{1'b1, 32'h0000_0105, 32'hDEADBEEF, 0, 32'h1111_1111, 0, 32'h0, 1'b0, 1};
    tbl[1] = '{1'b0, 32'h8000_0023, 32'hFFFF_FFFF, 0, 32'h0000_1234, 0, 32'h0000_1234, 1'b0, 1};
    tbl[2] = '{1'b0, {WB_IF_PADS, 30'h44}, 32'h0, 5, 32'hCAFE_0001, 1, 32'hCAFE_0001, 1'b0, 6};
    tbl[3] = '{1'b0, {WB_IF_DEBUG, 30'h8}, 32'h0, 15, 32'h0000_55AA, 0, 32'h0000_55AA, 1'b0, 16};
    tbl[4] = '{1'b0, {WB_IF_ENTROPY, 30'h3}, 32'h0, 16, 32'h0000_7777, 2, 32'h0, 1'b1, 16};
    tbl[5] = '{1'b1, {WB_IF_PROG, 30'h10}, 32'h0000_A5A5, -1, 32'h0, 0, 32'h0, 1'b1, 16};
    tbl[6] = '{1'b1, 32'h4000_0000, 32'h0000_1357, 2, 32'h9999_9999, 7, 32'h0, 1'b0, 3};
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_outputs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.wbm_cyc_o, bus.wbm_stb_o,
                        bus.wbm_we_o, busy, timeout_cnt}, 64'h0);
    chk("rst_wbm_adr_dat", {bus.wbm_adr_o, bus.wbm_dat_o}, 64'h0);
    repeat (2) @(negedge clk);
    chk("rst_held_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 7; i++)
      run_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].dly, tbl[i].rd, tbl[i].wt,
                tbl[i].x_rdata, tbl[i].x_err, tbl[i].x_len);
    chk("vec_timeout_cnt", 64'(timeout_cnt), 64'd2);
    m_tcnt = 2;

    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      adr = $urandom;
      dat = $urandom;
      rd  = $urandom;
      dly = int'($urandom_range(0, 21)) - 1;
      model(we, rd, dly, r, e, len);
      if (e && m_tcnt < 255) m_tcnt++;
      run_check($sformatf("rnd%0d", i), we, adr, dat, dly, rd, int'($urandom_range(0, 3)), r, e, len);
      chk($sformatf("rnd%0d_timeout_cnt", i), 64'(timeout_cnt), 64'(m_tcnt));
    end

    ack_delay     = 5;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'h8000_0040;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_bus_stb_pre", 64'(bus.wbm_stb_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 64'd0);
    chk("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("async_rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
    chk("async_rst_busy_ready", {busy, bus.cmd_ready}, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_tcnt = 0;
    @(negedge clk);
    run_check("post_rst_write", 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 0, 32'h1, 0, 32'h0, 1'b0, 1);

    for (int i = 0; i < 300; i++) begin
      logic ok, ra;
      int   lat;
      txn(1'b0, 32'hC000_0000 + 32'(i), 32'h0, -1, 32'h0, 0, len, lat, ok, r, e, ra);
      if (m_tcnt < 255) m_tcnt++;
      if (i == 0 || i == 254 || i == 299) begin
        chk($sformatf("sat%0d_err", i), 64'(e), 64'd1);
        chk($sformatf("sat%0d_len", i), 64'(len), 64'(TIMEOUT));
        chk($sformatf("sat%0d_timeout_cnt", i), 64'(timeout_cnt), 64'(m_tcnt));
      end
    end
    chk("sat_final_255", 64'(timeout_cnt), 64'd255);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
